// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Drives a chain of NUM_CORES accumulator cores through one job:
//   IDLE  -> accept a job command (item count)
//   INIT  -> one-cycle broadcast clear of every core accumulator
//   EXEC  -> forward each item of the source stream to the cores (exec strobe)
//   DRAIN -> three cycles so the cores' 3-stage accumulate pipeline settles
//   LOAD  -> copy the working accumulators onto the chain, emit core 0's result
//   SHIFT -> shift the chain one position per accepted beat, emit cores 1..N-1
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   cmd_valid/cmd_ready         job command handshake, cmd_count = items in job
//   src_valid/src_ready         item stream handshake, src_data = item index
//   init                        accumulator-clear pulse to all cores
//   exec                        execute strobe to all cores
//   exec_src_data               item index registered on each exec handshake
//   update                      select working accumulators onto the chain
//   out_period                  shift the accumulator chain by one position
//   chain_acc                   accumulator value at the chain head (core 0)
//   out_valid/out_ready/out_data result stream, out_data is chain_acc
//   busy                        high whenever not idle
//   done                        one-cycle pulse on the final result beat
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter int NUM_CORES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [31:0]      src_data,
    output logic             init,
    output logic             exec,
    output logic [31:0]      exec_src_data,
    output logic             update,
    output logic             out_period,
    input  logic [31:0]      chain_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done
);

    localparam int BEAT_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CORES - 1);
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EXEC,
        S_DRAIN,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   remaining_reg, remaining_next;
    logic [1:0]         drain_reg, drain_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;
    logic [31:0]        exec_src_data_reg;

    // Ungated versions of the control outputs; the ports below force them
    // low while reset is asserted, regardless of the current state.
    logic cmd_ready_c, src_ready_c, init_c, exec_c, update_c;
    logic out_period_c, out_valid_c, done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            remaining_reg     <= '0;
            drain_reg         <= '0;
            beat_reg          <= '0;
            exec_src_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            drain_reg     <= drain_next;
            beat_reg      <= beat_next;
            if (exec_c) begin
                exec_src_data_reg <= src_data;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        drain_next     = drain_reg;
        beat_next      = beat_reg;
        cmd_ready_c    = 1'b0;
        src_ready_c    = 1'b0;
        init_c         = 1'b0;
        exec_c         = 1'b0;
        update_c       = 1'b0;
        out_period_c   = 1'b0;
        out_valid_c    = 1'b0;
        done_c         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    remaining_next = cmd_count;
                    state_next     = S_INIT;
                end
            end

            S_INIT: begin
                init_c     = 1'b1;
                drain_next = '0;
                beat_next  = '0;
                state_next = (remaining_reg != '0) ? S_EXEC : S_DRAIN;
            end

            S_EXEC: begin
                src_ready_c = 1'b1;
                if (src_valid) begin
                    exec_c         = 1'b1;
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Three cycles here put the last exec at least four cycles
                // before LOAD, enough for the cores' accumulate pipeline.
                if (drain_reg == DRAIN_LAST) begin
                    drain_next = '0;
                    state_next = S_LOAD;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end

            S_LOAD: begin
                // update stays high through a stall so core 0's working
                // accumulator remains visible on the chain head.
                update_c     = 1'b1;
                out_valid_c  = 1'b1;
                out_period_c = out_ready;
                if (out_ready) begin
                    if (NUM_CORES == 1) begin
                        done_c     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        beat_next  = BEAT_W'(1);
                        state_next = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                out_valid_c  = 1'b1;
                out_period_c = out_ready;
                if (out_ready) begin
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        done_c     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign cmd_ready     = cmd_ready_c  & ~reset;
    assign src_ready     = src_ready_c  & ~reset;
    assign init          = init_c       & ~reset;
    assign exec          = exec_c       & ~reset;
    assign update        = update_c     & ~reset;
    assign out_period    = out_period_c & ~reset;
    assign out_valid     = out_valid_c  & ~reset;
    assign done          = done_c       & ~reset;
    assign busy          = (state_reg != S_IDLE) & ~reset;
    assign exec_src_data = exec_src_data_reg;
    assign out_data      = chain_acc;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: NUM_CORES, default 8, number of cores in the accumulator chain.
REQ-002 Parameter: CNT_W, default 16, width of the item-count field.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 Port: cmd_valid / cmd_ready  input / output  1 / 1  job-command handshake.
REQ-006 Port: cmd_count  input  CNT_W  number of items in the job; 0 is legal.
REQ-007 Port: src_valid / src_ready  input / output  1 / 1  item-stream handshake.
REQ-008 Port: src_data  input  32  item index, forwarded to the cores.
REQ-009 Port: init  output  1  broadcast accumulator-clear pulse to all cores.
REQ-010 Port: exec  output  1  broadcast execute strobe to all cores.
REQ-011 Port: exec_src_data  output  32  registered item index; valid the cycle after exec.
REQ-012 Port: update  output  1  selects each core's working accumulator onto the chain.
REQ-013 Port: out_period  output  1  shifts the core accumulator chain by one position.
REQ-014 Port: chain_acc  input  32  acc output of core 0, the chain head.
REQ-015 Port: out_valid / out_ready / out_data  output / input / output  1 / 1 / 32  result stream.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse when a job completes.

Function
REQ-018 The block SHALL implement the states IDLE, INIT, EXEC, DRAIN, LOAD, SHIFT.
REQ-019 In IDLE: cmd_ready=1; on cmd_valid the block latches cmd_count into remaining and moves to INIT; cmd_ready=0 in all other states.
REQ-020 In INIT, lasting exactly 1 cycle: init=1; next state is EXEC if remaining!=0, else DRAIN.
REQ-021 In EXEC: src_ready=1 and exec=src_valid&src_ready, combinational; exec is 0 outside EXEC.
REQ-022 On each EXEC handshake: exec_src_data<=src_data, held until the next handshake; remaining decrements.
REQ-023 The handshake that takes remaining from 1 to 0 SHALL move the block to DRAIN on the next cycle; src stalls insert idle cycles with exec=0.
REQ-024 DRAIN SHALL last exactly 3 cycles, then go to LOAD; the last exec at cycle t therefore gives LOAD no earlier than t+4, which covers the core's 3-stage accumulate pipeline.
REQ-025 In LOAD: update=1, out_valid=1, out_data=chain_acc, out_period=out_ready.
REQ-026 LOAD on out_ready SHALL go to SHIFT with beat counter=1; it holds while out_ready=0, with update kept high.
REQ-027 In SHIFT: update=0, out_valid=1, out_data=chain_acc, out_period=out_ready.
REQ-028 In SHIFT, each handshake increments the beat counter; the handshake at beat NUM_CORES-1 goes to IDLE with done=1 that cycle.
REQ-029 Exactly NUM_CORES out beats SHALL be produced per job, in core order 0..NUM_CORES-1.
REQ-030 out_period SHALL never be high without out_valid&out_ready, so no result is lost under backpressure.
REQ-031 out_data SHALL equal chain_acc combinationally; the block does not buffer results.
REQ-032 cmd_valid outside IDLE SHALL be ignored, with no queuing; src_valid outside EXEC SHALL be ignored, with src_ready=0.
REQ-033 cmd_count wraps are not permitted; remaining is CNT_W bits and counts down only.
REQ-034 init and exec SHALL never be high in the same cycle.

Reset
REQ-035 On reset=1 at a clock edge: state=IDLE, remaining=0, beat counter=0, exec_src_data=0.
REQ-036 While in reset: init=exec=update=out_period=out_valid=done=busy=0, cmd_ready=0, src_ready=0.
REQ-037 Reset asserted mid-job (any state) SHALL abort the job with no done pulse; core accumulators are cleared by the next job's INIT.
REQ-038 The first cycle after reset deasserts SHALL be IDLE with cmd_ready=1.

Verification
REQ-039 NUM_CORES=8, cmd_count=4, src always valid with data 1,2,3,4, out_ready=1 -> init at cycle s; exec at s+1..s+4; exec_src_data 1..4 at s+2..s+5; update at s+8; 8 out beats s+8..s+15; done at s+15.
REQ-040 cmd_count=0 -> INIT, 3 DRAIN cycles, no exec, then 8 beats each equal to the chain_acc driven by the bench (core model gives 0).
REQ-041 cmd_count=3 with src_valid low for 2 cycles between items -> exec pulses exactly 3, DRAIN begins the cycle after the 3rd exec.
REQ-042 out_ready toggled 1,0,0,1,... during LOAD/SHIFT -> out_period high only on ready cycles; beat count still 8; update held through the LOAD stall.
REQ-043 reset pulsed during EXEC after 2 of 5 items -> all outputs 0 next cycle; new job of 1 item runs to completion with done.
REQ-044 With the 8-core model (item_memory[i]=i, acc ^= rotr(m2,m2)) and items {5} -> every core outputs rotr(5,5)=0x28000000.
